// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_ctrl
// Purpose  : Sequencing controller for the serial pattern detector. Accepts
//            parallel words over valid/ready, serializes them MSB-first one
//            bit per clock, matches a programmable PAT_W-bit pattern on the
//            resulting stream (overlapping or non-overlapping) and reports a
//            pulse per match plus a saturating per-word match count.
// Ports    :
//   clk          - system clock, rising edge
//   rst          - asynchronous active-low reset
//   cfg_we       - configuration write strobe, honoured only in IDLE
//   cfg_pattern  - new pattern, MSB is the first stream bit expected
//   cfg_overlap  - 1 = overlapping detection, 0 = non-overlapping
//   in_valid     - word available
//   in_data      - word to serialize
//   in_ready     - controller can accept a word (IDLE)
//   ser_valid    - ser_bit carries a live stream bit
//   ser_bit      - current serialized bit
//   match        - one-cycle pulse per detected pattern
//   done         - one-cycle pulse when a word has been fully processed
//   match_count  - matches in the current or last word (saturating)
//   busy         - high in SHIFT and DONE
// Revision : 1.0 - initial release
// ============================================================================
module seq_det_ctrl #(
  parameter int               WORD_W  = 8,
  parameter int               PAT_W   = 4,        // must be >= 2
  parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
  parameter int               CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              ser_valid,
  output logic              ser_bit,
  output logic              match,
  output logic              done,
  output logic [CNT_W-1:0]  match_count,
  output logic              busy
);

  localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int FILL_W = $clog2(PAT_W + 1);

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_SHIFT = 2'd1;
  localparam logic [1:0] C_DONE  = 2'd2;

  localparam logic [IDX_W-1:0]  C_LAST_IDX  = IDX_W'(WORD_W - 1);
  localparam logic [FILL_W-1:0] C_FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  C_CNT_MAX   = '1;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [PAT_W-1:0]  r_pattern;
  logic              r_overlap;
  logic [WORD_W-1:0] r_shift;
  logic [PAT_W-2:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [IDX_W-1:0]  r_idx;
  logic              r_match;
  logic [CNT_W-1:0]  r_count;

  logic              w_cur_bit;
  logic [PAT_W-1:0]  w_window;
  logic [FILL_W-1:0] w_fill_inc;
  logic              w_hit;

  // The stream bit this cycle is the MSB of the shift register; the match
  // window is the previous PAT_W-1 bits followed by it.
  assign w_cur_bit = r_shift[WORD_W-1];
  assign w_window  = {r_hist, w_cur_bit};

  // Fill count saturates at PAT_W, so "at least PAT_W bits seen" reduces to
  // equality with the full value.
  assign w_fill_inc = (r_fill == C_FILL_FULL) ? r_fill : r_fill + 1'b1;
  assign w_hit      = (r_state == C_SHIFT) && (w_window == r_pattern) &&
                      (w_fill_inc == C_FILL_FULL);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      C_IDLE:  if (in_valid) w_next_state = C_SHIFT;
      C_SHIFT: if (r_idx == C_LAST_IDX) w_next_state = C_DONE;
      C_DONE:  w_next_state = C_IDLE;
      default: w_next_state = C_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: configuration, serializer, detector history and counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pattern <= PATTERN;
      r_overlap <= 1'b1;
      r_shift   <= '0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_idx     <= '0;
      r_match   <= 1'b0;
      r_count   <= '0;
    end else begin
      // The hit of the current bit becomes visible one cycle later, which
      // places the last bit's pulse in the DONE cycle.
      r_match <= w_hit;
      case (r_state)
        C_IDLE: begin
          // Config is latched on the same edge as an accept, so a word
          // accepted together with a write already sees the new settings.
          if (cfg_we) begin
            r_pattern <= cfg_pattern;
            r_overlap <= cfg_overlap;
          end
          if (in_valid) begin
            r_shift <= in_data;
            r_hist  <= '0;
            r_fill  <= '0;
            r_idx   <= '0;
            r_count <= '0;
          end
        end
        C_SHIFT: begin
          r_shift <= {r_shift[WORD_W-2:0], 1'b0};
          r_idx   <= r_idx + 1'b1;
          // Non-overlap mode discards the hit bit so the next match must be
          // built entirely from fresh bits.
          if (w_hit && !r_overlap) begin
            r_hist <= '0;
            r_fill <= '0;
          end else begin
            r_hist <= w_window[PAT_W-2:0];
            r_fill <= w_fill_inc;
          end
          if (w_hit && (r_count != C_CNT_MAX)) begin
            r_count <= r_count + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready    = (r_state == C_IDLE);
    ser_valid   = (r_state == C_SHIFT);
    ser_bit     = (r_state == C_SHIFT) & w_cur_bit;
    done        = (r_state == C_DONE);
    busy        = (r_state == C_SHIFT) || (r_state == C_DONE);
    match       = r_match;
    match_count = r_count;
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_det_ctrl
// Purpose  : Directed self-checking bench for seq_det_ctrl. A second instance
//            with a 2-bit counter shares all inputs to observe saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_pattern = 4'b0000;
  logic       cfg_overlap = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       in_ready, ser_valid, ser_bit, match, done, busy;
  logic [3:0] match_count;
  logic       in_ready_s, ser_valid_s, ser_bit_s, match_s, done_s, busy_s;
  logic [1:0] match_count_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_det_ctrl #(.WORD_W(8), .PAT_W(4), .PATTERN(4'b1001), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ser_valid(ser_valid), .ser_bit(ser_bit),
    .match(match), .done(done), .match_count(match_count), .busy(busy)
  );

  seq_det_ctrl #(.WORD_W(8), .PAT_W(4), .PATTERN(4'b1001), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_s), .ser_valid(ser_valid_s), .ser_bit(ser_bit_s),
    .match(match_s), .done(done_s), .match_count(match_count_s), .busy(busy_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},    in_ready,    1);
    check({tag, "_ser_valid"},   ser_valid,   0);
    check({tag, "_ser_bit"},     ser_bit,     0);
    check({tag, "_match"},       match,       0);
    check({tag, "_done"},        done,        0);
    check({tag, "_match_count"}, match_count, 0);
    check({tag, "_busy"},        busy,        0);
  endtask

  // Called at a negedge while the DUT is in IDLE. mask[k] = 1 when bit index k
  // completes a match. Returns at the negedge of the first IDLE cycle after
  // DONE, so a back-to-back call is accepted on the very next edge.
  task automatic run_word(input string tag, input logic [7:0] word,
                          input logic [7:0] mask, input int exp_cnt,
                          input logic hold, input logic [7:0] next_word,
                          input logic mid_cfg);
    logic e;
    int   exp_sat;
    exp_sat  = (exp_cnt > 3) ? 3 : exp_cnt;
    in_valid = 1'b1;
    in_data  = word;
    check({tag, "_ready_pre"}, in_ready, 1);
    @(negedge clk);
    cfg_we = 1'b0;
    if (hold) in_data = next_word;
    else      in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (mid_cfg && k == 2) begin
        cfg_we      = 1'b1;
        cfg_pattern = 4'b1111;
        cfg_overlap = 1'b1;
      end
      if (mid_cfg && k == 3) cfg_we = 1'b0;
      e = (k == 0) ? 1'b0 : mask[k-1];
      check({tag, "_ser_valid"}, ser_valid, 1);
      check({tag, "_ser_bit"},   ser_bit,   word[7-k]);
      check({tag, "_ready_low"}, in_ready,  0);
      check({tag, "_match"},     match,     e);
      check({tag, "_done_low"},  done,      0);
      check({tag, "_busy"},      busy,      1);
      @(negedge clk);
    end
    check({tag, "_done"},        done,          1);
    check({tag, "_match_last"},  match,         mask[7]);
    check({tag, "_count"},       match_count,   exp_cnt);
    check({tag, "_count_sat"},   match_count_s, exp_sat);
    check({tag, "_busy_done"},   busy,          1);
    check({tag, "_ready_done"},  in_ready,      0);
    check({tag, "_sv_done"},     ser_valid,     0);
    @(negedge clk);
    check({tag, "_done_after"},  done,          0);
    check({tag, "_ready_after"}, in_ready,      1);
    check({tag, "_busy_after"},  busy,          0);
    check({tag, "_match_after"}, match,         0);
    check({tag, "_count_hold"},  match_count,   exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish in time");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Default pattern 1001, overlap: matches after bits 3 and 7
    run_word("t1", 8'b1001_1001, 8'b1000_1000, 2, 1'b0, 8'h00, 1'b0);

    // Overlap vs non-overlap; config written on the accept cycle
    run_word("t2o", 8'b1001_0010, 8'b0100_1000, 2, 1'b0, 8'h00, 1'b0);
    cfg_we = 1'b1; cfg_pattern = 4'b1001; cfg_overlap = 1'b0;
    run_word("t2n", 8'b1001_0010, 8'b0000_1000, 1, 1'b0, 8'h00, 1'b0);

    // Reprogramming in IDLE, then a write during SHIFT must be ignored
    @(negedge clk);
    cfg_we = 1'b1; cfg_pattern = 4'b0110; cfg_overlap = 1'b0;
    @(negedge clk);
    cfg_we = 1'b0;
    run_word("t3a", 8'b0110_1100, 8'b0000_1000, 1, 1'b0, 8'h00, 1'b1);
    run_word("t3b", 8'b0110_1100, 8'b0000_1000, 1, 1'b0, 8'h00, 1'b0);

    // Back-to-back words with in_valid held high
    @(negedge clk);
    cfg_we = 1'b1; cfg_pattern = 4'b1001; cfg_overlap = 1'b1;
    run_word("t4a", 8'hA5, 8'b0010_0000, 1, 1'b1, 8'h3C, 1'b0);
    run_word("t4b", 8'h3C, 8'b0000_0000, 0, 1'b0, 8'h00, 1'b0);

    // Saturation: five hits, 2-bit counter stops at 3
    @(negedge clk);
    cfg_we = 1'b1; cfg_pattern = 4'b1111; cfg_overlap = 1'b1;
    run_word("t5", 8'hFF, 8'b1111_1000, 5, 1'b0, 8'h00, 1'b0);

    // Asynchronous reset at bit index 4
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'b1001_1001;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_bit4", ser_bit, 1);
    check("t6_busy_pre", busy, 1);
    rst = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    @(negedge clk);
    check_reset_outputs("t6_held");
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("t6_no_done", done, 0);
      check("t6_ready", in_ready, 1);
      check("t6_idle", busy, 0);
    end
    // Pattern and overlap back to 1001 / overlapping
    run_word("t6r", 8'b1001_0010, 8'b0100_1000, 2, 1'b0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
